// File: rtl/lsu_arb_if.sv
// lsu_arb_if: signal bundle between the two requesters, lsu_arb and the LSU port.
// Latency: none (wires only).
// Backpressure: requesters hold req/we/addr/wdata stable until their gnt bit is seen.
//
// Ports (slave = arbiter view):
//   requester side : req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i -> gnt_o
//   response side  : rvalid_o, err_o, rdata_o
//   LSU side       : lsu_st_en_o, lsu_addr_o, lsu_st_data_o <- lsu_ld_data_i
interface lsu_arb_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [1:0]        req_i;
  logic [1:0]        we_i;
  logic [ADDR_W-1:0] addr0_i;
  logic [ADDR_W-1:0] addr1_i;
  logic [DATA_W-1:0] wdata0_i;
  logic [DATA_W-1:0] wdata1_i;
  logic [1:0]        gnt_o;
  logic [1:0]        rvalid_o;
  logic              err_o;
  logic [DATA_W-1:0] rdata_o;
  logic              lsu_st_en_o;
  logic [ADDR_W-1:0] lsu_addr_o;
  logic [DATA_W-1:0] lsu_st_data_o;
  logic [DATA_W-1:0] lsu_ld_data_i;

  // Arbiter side.
  modport slave (
    input  req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, lsu_ld_data_i,
    output gnt_o, rvalid_o, err_o, rdata_o, lsu_st_en_o, lsu_addr_o, lsu_st_data_o
  );

  // Requester / LSU side (testbench or surrounding logic).
  modport master (
    output req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, lsu_ld_data_i,
    input  gnt_o, rvalid_o, err_o, rdata_o, lsu_st_en_o, lsu_addr_o, lsu_st_data_o
  );
endinterface

// File: rtl/lsu_arb.sv
// lsu_arb: two-requester round-robin arbiter sharing the single LSU port.
// Latency: command on the LSU the cycle after acceptance; rvalid_o pulses the cycle after that.
// Backpressure: gnt_o is held low while a command is in flight; one transaction per 2 cycles.
//
// Ports:
//   clk_i       clock, all state on the rising edge
//   rst_ni      synchronous active-low reset
//   bus.slave   requester commands and responses, plus the LSU st_en/addr/st_data/ld_data port
module lsu_arb #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input logic      clk_i,
  input logic      rst_ni,
  lsu_arb_if.slave bus
);

  // Legal map: data 0x000-0x7FF, peripherals 0x800-0x8FF, read-only switches 0x900-0x90F.
  localparam logic [ADDR_W-1:0] SW_BASE = ADDR_W'(12'h900);
  localparam logic [ADDR_W-1:0] MAP_END = ADDR_W'(12'h910);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              bad_q, bad_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [1:0]        gnt;
  logic              accept;
  logic              sel;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_bad;

  // Misaligned, beyond the map, or a store into the switch window.
  // Anything reaching the last term is already below MAP_END.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a, input logic we);
    return (a[1:0] != 2'b00) || (a >= MAP_END) || (we && (a >= SW_BASE));
  endfunction

  // Arbitration: a lone requester always wins; under contention prio_q picks.
  // Nothing is granted during reset or while a command occupies the LSU.
  always_comb begin
    gnt    = 2'b00;
    sel    = 1'b0;
    accept = 1'b0;
    if ((state_q == IDLE) && rst_ni) begin
      case (bus.req_i)
        2'b01:   sel = 1'b0;
        2'b10:   sel = 1'b1;
        2'b11:   sel = prio_q;
        default: sel = 1'b0;
      endcase
      accept = |bus.req_i;
      gnt    = accept ? (sel ? 2'b10 : 2'b01) : 2'b00;
    end
  end

  // Command of the selected requester.
  always_comb begin
    sel_we    = sel ? bus.we_i[1]   : bus.we_i[0];
    sel_addr  = sel ? bus.addr1_i   : bus.addr0_i;
    sel_wdata = sel ? bus.wdata1_i  : bus.wdata0_i;
    sel_bad   = addr_bad(sel_addr, sel_we);
  end

  // FSM next state and registered datapath.
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    bad_d    = bad_q;
    rvalid_d = 2'b00;
    err_d    = err_q;
    rdata_d  = rdata_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          owner_d = sel;
          // The loser of this round is favoured next time.
          prio_d  = ~sel;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          bad_d   = sel_bad;
        end
      end
      BUSY: begin
        // The LSU read is combinational, so ld_data is valid for the whole
        // BUSY cycle; sample it here so the load completes before any later
        // store can be accepted.
        state_d  = IDLE;
        rvalid_d = owner_q ? 2'b10 : 2'b01;
        err_d    = bad_q;
        rdata_d  = (we_q || bad_q) ? '0 : bus.lsu_ld_data_i;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      bad_q    <= 1'b0;
      rvalid_q <= 2'b00;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      bad_q    <= bad_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.gnt_o         = gnt;
  assign bus.rvalid_o      = rvalid_q;
  assign bus.err_o         = err_q;
  assign bus.rdata_o       = rdata_q;
  assign bus.lsu_addr_o    = addr_q;
  assign bus.lsu_st_data_o = wdata_q;
  // rst_ni gates the strobe directly so a store caught by reset never commits.
  assign bus.lsu_st_en_o   = (state_q == BUSY) && we_q && !bad_q && rst_ni;

endmodule

// File: tb/tb_lsu_arb.sv
`timescale 1ns/1ps
module tb_lsu_arb;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  lsu_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  // Requester drive
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [11:0] a0 = '0, a1 = '0;
  logic [31:0] d0 = '0, d1 = '0;
  assign bus.req_i    = {req1, req0};
  assign bus.we_i     = {we1, we0};
  assign bus.addr0_i  = a0;
  assign bus.addr1_i  = a1;
  assign bus.wdata0_i = d0;
  assign bus.wdata1_i = d1;

  // LSU: combinational read, store commits at the rising edge
  logic [31:0] lsu_mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  assign bus.lsu_ld_data_i = lsu_mem[bus.lsu_addr_o[11:2]];
  always @(posedge clk) if (bus.lsu_st_en_o) lsu_mem[bus.lsu_addr_o[11:2]] <= bus.lsu_st_data_o;

  function automatic logic [31:0] init_word(input int i);
    return 32'hA500_0000 + i * 32'h0000_0101;
  endfunction

  // Bookkeeping
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic bit is_err(input bit we, input logic [11:0] a);
    return (a[1:0] != 2'b00) || (a >= 12'h910) || (we && a >= 12'h900 && a < 12'h910);
  endfunction

  typedef struct {
    int          owner;
    bit          we;
    logic [11:0] addr;
    logic [31:0] data;
    bit          err;
  } txn_t;

  typedef struct {
    int          owner;
    bit          err;
    logic [31:0] rdata;
    int          due;
  } rsp_t;

  rsp_t        sb[$];
  int          grant_log[$];
  int          rv_cycles[$];
  int          st_en_cnt = 0;
  logic [31:0] last_rdata = '0;
  bit          last_err = 1'b0;
  int          last_owner = -1;

  // Reference model: one transaction at a time; accepted at an edge, occupies
  // the following cycle, answered the cycle after.
  txn_t pend;
  int   acc_cyc = -100;
  bit   prio_m = 1'b0;

  always @(negedge clk) begin
    logic [1:0] req;
    logic [1:0] eg;
    bit         busy;
    bit         legal_st;
    rsp_t       r;
    int         k;
    if (!rst_n) begin
      chk("gnt_in_reset", 32'(bus.gnt_o), 32'd0);
      chk("st_en_in_reset", 32'(bus.lsu_st_en_o), 32'd0);
      sb.delete();
      prio_m  = 1'b0;
      acc_cyc = -100;
    end else begin
      busy = (cyc == acc_cyc);
      if (busy) begin
        legal_st = pend.we && !pend.err;
        chk("st_en_busy", 32'(bus.lsu_st_en_o), 32'(legal_st));
        chk("lsu_addr", 32'(bus.lsu_addr_o), 32'(pend.addr));
        if (legal_st) chk("lsu_st_data", bus.lsu_st_data_o, pend.data);
        r.owner = pend.owner;
        r.err   = pend.err;
        r.due   = cyc + 1;
        if (pend.err) r.rdata = '0;
        else if (pend.we) begin
          ref_mem[pend.addr[11:2]] = pend.data;
          r.rdata = '0;
        end else r.rdata = ref_mem[pend.addr[11:2]];
        sb.push_back(r);
      end else begin
        chk("st_en_idle", 32'(bus.lsu_st_en_o), 32'd0);
      end
      req = {req1, req0};
      if (busy) eg = 2'b00;
      else if (req == 2'b11) eg = prio_m ? 2'b10 : 2'b01;
      else eg = req;
      chk("gnt", 32'(bus.gnt_o), 32'(eg));
      if (eg != 2'b00) begin
        k = eg[1] ? 1 : 0;
        pend.owner = k;
        pend.we    = (k == 1) ? we1 : we0;
        pend.addr  = (k == 1) ? a1 : a0;
        pend.data  = (k == 1) ? d1 : d0;
        pend.err   = is_err(pend.we, pend.addr);
        prio_m     = (k == 0);
        acc_cyc    = cyc + 1;
        grant_log.push_back(k);
      end
    end
    if (bus.lsu_st_en_o) st_en_cnt++;
  end

  // Monitor: pops the scoreboard whenever a response appears
  always @(negedge clk) begin
    rsp_t r;
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        chk("rvalid_missing_at", 32'(cyc), 32'(sb[0].due));
        void'(sb.pop_front());
      end
      if (bus.rvalid_o != 2'b00) begin
        rv_cycles.push_back(cyc);
        if (sb.size() == 0) begin
          chk("rvalid_unexpected", 32'(bus.rvalid_o), 32'd0);
        end else begin
          r = sb.pop_front();
          chk("rvalid_owner", 32'(bus.rvalid_o), (r.owner == 1) ? 32'd2 : 32'd1);
          chk("rsp_cycle", 32'(cyc), 32'(r.due));
          chk("rsp_err", 32'(bus.err_o), 32'(r.err));
          chk("rsp_rdata", bus.rdata_o, r.rdata);
          last_rdata = bus.rdata_o;
          last_err   = bus.err_o;
          last_owner = bus.rvalid_o[1] ? 1 : 0;
        end
      end
    end
  end

  // Present a command on requester k and hold it until granted
  task automatic issue(input int k, input bit we, input logic [11:0] a, input logic [31:0] d);
    int t;
    t = 0;
    if (k == 0) begin req0 = 1'b1; we0 = we; a0 = a; d0 = d; end
    else        begin req1 = 1'b1; we1 = we; a1 = a; d1 = d; end
    forever begin
      @(negedge clk);
      if (bus.gnt_o[k]) break;
      t++;
      if (t > 60) begin
        checks++;
        errors++;
        $display("FAIL grant_timeout req%0d: no grant after %0d cycles, required within 60", k, t);
        break;
      end
    end
    @(posedge clk); #1;
    if (k == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [11:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4: return 12'($urandom_range(0, 15) << 2);
      5:             return 12'h800 + 12'($urandom_range(0, 63) << 2);
      6:             return 12'h900 + 12'($urandom_range(0, 3) << 2);
      7:             return 12'($urandom_range(0, 15) << 2) | 12'($urandom_range(1, 3));
      8:             return 12'h910 + 12'($urandom_range(0, 443) << 2);
      default:       return 12'($urandom_range(0, 4095));
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) begin
      lsu_mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with both requests pending
    req0 = 1'b1; req1 = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_gnt", 32'(bus.gnt_o), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid_o), 32'd0);
    chk("rst_err", 32'(bus.err_o), 32'd0);
    chk("rst_rdata", bus.rdata_o, 32'd0);
    chk("rst_st_en", 32'(bus.lsu_st_en_o), 32'd0);
    chk("rst_lsu_addr", 32'(bus.lsu_addr_o), 32'd0);
    chk("rst_st_data", bus.lsu_st_data_o, 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single store then load
    st_en_cnt = 0;
    issue(0, 1'b1, 12'h000, 32'hDEADBEEF);
    drain();
    chk("store_err", 32'(last_err), 32'd0);
    issue(0, 1'b0, 12'h000, 32'h0);
    drain();
    chk("store_st_en_cycles", 32'(st_en_cnt), 32'd1);
    chk("load_rdata", last_rdata, 32'hDEADBEEF);
    chk("load_owner", 32'(last_owner), 32'd0);

    // Contention after reset: both hold loads back to back
    do_reset();
    grant_log.delete();
    rv_cycles.delete();
    fork
      begin for (int i = 0; i < 4; i++) issue(0, 1'b0, 12'(i * 8), 32'h0); end
      begin for (int j = 0; j < 4; j++) issue(1, 1'b0, 12'(j * 8 + 4), 32'h0); end
    join
    drain();
    chk("contention_grants", 32'(grant_log.size()), 32'd8);
    chk("contention_rvalids", 32'(rv_cycles.size()), 32'd8);
    for (int i = 0; i < grant_log.size(); i++) chk("contention_order", 32'(grant_log[i]), 32'(i % 2));
    for (int i = 1; i < rv_cycles.size(); i++)
      chk("contention_rvalid_spacing", 32'(rv_cycles[i] - rv_cycles[i-1]), 32'd2);

    // Cross-requester read-after-write
    issue(1, 1'b1, 12'h7FC, 32'h12345678);
    issue(0, 1'b0, 12'h7FC, 32'h0);
    drain();
    chk("raw_rdata", last_rdata, 32'h12345678);
    chk("raw_owner", 32'(last_owner), 32'd0);

    // Error responses
    st_en_cnt = 0;
    issue(0, 1'b0, 12'h002, 32'h0);
    drain();
    chk("err_misaligned", 32'(last_err), 32'd1);
    chk("err_misaligned_rdata", last_rdata, 32'd0);
    issue(1, 1'b0, 12'hA00, 32'h0);
    drain();
    chk("err_range", 32'(last_err), 32'd1);
    chk("err_range_rdata", last_rdata, 32'd0);
    issue(0, 1'b1, 12'h900, 32'h11111111);
    drain();
    chk("err_switch_store", 32'(last_err), 32'd1);
    chk("err_switch_rdata", last_rdata, 32'd0);
    chk("err_st_en_cycles", 32'(st_en_cnt), 32'd0);
    chk("err_mem0_kept", lsu_mem[0], 32'hDEADBEEF);

    // Peripheral path
    issue(1, 1'b1, 12'h880, 32'h0000007F);
    issue(1, 1'b0, 12'h880, 32'h0);
    drain();
    chk("periph_rdata", last_rdata, 32'h0000007F);
    chk("periph_err", 32'(last_err), 32'd0);

    // Reset during the BUSY cycle of a store
    issue(0, 1'b1, 12'h010, 32'hCAFEF00D);
    rst_n = 1'b0;
    #1;
    chk("reset_st_en", 32'(bus.lsu_st_en_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    grant_log.delete();
    fork
      issue(0, 1'b0, 12'h010, 32'h0);
      issue(1, 1'b0, 12'h014, 32'h0);
    join
    drain();
    chk("reset_grants", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() > 0) chk("reset_first_grant", 32'(grant_log[0]), 32'd0);
    chk("reset_mem_kept", lsu_mem[4], init_word(4));

    // Randomized traffic from both requesters
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          int unsigned gap;
          gap = $urandom_range(0, 3);
          repeat (gap) begin @(posedge clk); #1; end
          issue(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
        end
      end
      begin
        for (int j = 0; j < 30; j++) begin
          int unsigned gap;
          gap = $urandom_range(0, 3);
          repeat (gap) begin @(posedge clk); #1; end
          issue(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
        end
      end
    join
    drain();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
